// File: rtl/csa_accum_if.sv
// rtl/csa_accum_if.sv - beat input and result output bundle for csa_accum
//
// Purpose: groups the input beat handshake and the result handshake.
// Ports (signals):
//   in_valid/in_ready/in_data/in_last : operand beats, NOPS operands of BW bits
//   out_valid/out_ready/out_sum/out_ovf : resolved packet total and overflow flag
// Modports: master = producer of beats and consumer of results; slave = csa_accum.
interface csa_accum_if #(
  parameter int BW    = 8,
  parameter int NOPS  = 4,
  parameter int ACC_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NOPS*BW-1:0]   in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_sum;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/csa_accum.sv
// rtl/csa_accum.sv - multi-operand carry-save accumulator with segmented resolve
//
// Purpose: compresses each accepted beat of NOPS operands into a redundant
// sum/carry accumulator, then resolves the pair SEG bits per cycle at end of
// packet and presents the total with an exact overflow flag.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : csa_accum_if slave (beat input handshake, result output handshake)
module csa_accum #(
  parameter int BW    = 8,
  parameter int NOPS  = 4,
  parameter int ACC_W = 16,
  parameter int SEG   = 8
) (
  input  logic        clk,
  input  logic        rst,
  csa_accum_if.slave  bus
);

  localparam int R  = (ACC_W + SEG - 1) / SEG;
  localparam int PW = R * SEG;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUT} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  sum_q, carry_q;
  logic [ACC_W-1:0]  sum_d, carry_d;
  logic [ACC_W-1:0]  op_ext, maj;
  logic              ovf_q, drop_d;
  logic [CW-1:0]     seg_q;
  logic              cin_q;
  logic [PW-1:0]     res_q, res_d;
  logic [PW-1:0]     sum_pad, carry_pad;
  logic [SEG-1:0]    seg_a, seg_b, seg_s;
  logic              seg_co;
  logic              last_seg, res_hi, res_ovf;
  logic [ACC_W-1:0]  out_sum_q;
  logic              out_ovf_q;
  logic              in_ready_c, out_valid_c, accept, out_fire;

  // Chain of 3:2 compressors: each operand is folded into the running
  // sum/carry pair. The carry bit shifted out of the top is a genuine
  // 2^ACC_W contribution, so it is recorded rather than silently lost.
  always_comb begin
    sum_d   = (state_q == IDLE) ? '0 : sum_q;
    carry_d = (state_q == IDLE) ? '0 : carry_q;
    drop_d  = 1'b0;
    op_ext  = '0;
    maj     = '0;
    for (int k = 0; k < NOPS; k++) begin
      op_ext  = ACC_W'(bus.in_data[k*BW +: BW]);
      maj     = (sum_d & carry_d) | (sum_d & op_ext) | (carry_d & op_ext);
      sum_d   = sum_d ^ carry_d ^ op_ext;
      drop_d  = drop_d | maj[ACC_W-1];
      carry_d = {maj[ACC_W-2:0], 1'b0};
    end
  end

  // Resolve works on zero-padded copies so a partial top segment needs no
  // special casing; any bit landing above ACC_W in the padding is overflow.
  assign sum_pad   = PW'(sum_q);
  assign carry_pad = PW'(carry_q);

  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < R; i++) begin
      if (seg_q == CW'(i)) begin
        seg_a = sum_pad[i*SEG +: SEG];
        seg_b = carry_pad[i*SEG +: SEG];
      end
    end
    {seg_co, seg_s} = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, cin_q};
    res_d = res_q;
    for (int i = 0; i < R; i++) begin
      if (seg_q == CW'(i)) begin
        res_d[i*SEG +: SEG] = seg_s;
      end
    end
  end

  generate
    if (PW > ACC_W) begin : g_pad
      assign res_hi = |res_d[PW-1:ACC_W];
    end else begin : g_nopad
      assign res_hi = 1'b0;
    end
  endgenerate

  assign last_seg = (seg_q == CW'(R - 1));
  assign res_ovf  = ovf_q | seg_co | res_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = bus.in_last ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        if (last_seg) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = in_ready_c & bus.in_valid;
  assign out_fire = out_valid_c & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= '0;
      ovf_q     <= 1'b0;
      seg_q     <= '0;
      cin_q     <= 1'b0;
      res_q     <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_q | drop_d;
      end
      if (state_q == RESOLVE) begin
        res_q <= res_d;
        cin_q <= seg_co;
        seg_q <= seg_q + CW'(1);
        if (last_seg) begin
          // Outputs are only written here, so they hold through OUT stalls.
          out_sum_q <= res_d[ACC_W-1:0];
          out_ovf_q <= res_ovf;
          seg_q     <= '0;
        end
      end
      if (out_fire) begin
        sum_q   <= '0;
        carry_q <= '0;
        ovf_q   <= 1'b0;
        res_q   <= '0;
        cin_q   <= 1'b0;
        seg_q   <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accum.sv
// tb/tb_csa_accum.sv - directed self-checking bench for csa_accum
module tb_csa_accum;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  csa_accum_if #(.BW(8), .NOPS(4), .ACC_W(16)) b0 ();
  csa_accum_if #(.BW(4), .NOPS(8), .ACC_W(8))  b1 ();

  csa_accum #(.BW(8), .NOPS(4), .ACC_W(16), .SEG(8)) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
  );

  csa_accum #(.BW(4), .NOPS(8), .ACC_W(8), .SEG(3)) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a falling edge; the beat is taken on the following rising edge.
  task automatic send0(input logic [31:0] d, input logic last);
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    b0.in_last  = last;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.in_last  = 1'b0;
  endtask

  task automatic wait_out0(output int cycles);
    cycles = 0;
    while (!b0.out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_out1(output int cycles);
    cycles = 0;
    while (!b1.out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", b0.in_ready); end
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", b0.out_valid); end
    n_cmp++; if (b0.out_sum !== 16'h0) begin n_err++; $display("FAIL reset_out_sum got %h want 0000", b0.out_sum); end
    n_cmp++; if (b0.out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf got %0b want 0", b0.out_ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    send0({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_err++; $display("FAIL single_resolve_in_ready got %0b want 0", b0.in_ready); end
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid_c0 got %0b want 0", b0.out_valid); end
    @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid_c1 got %0b want 0", b0.out_valid); end
    @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", b0.out_valid); end
    n_cmp++; if (b0.out_sum !== 16'd10) begin n_err++; $display("FAIL single_sum got %0d want 10", b0.out_sum); end
    n_cmp++; if (b0.out_ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf got %0b want 0", b0.out_ovf); end
    @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin n_err++; $display("FAIL single_idle got valid=%0b ready=%0b want 0/1", b0.out_valid, b0.in_ready); end
  endtask

  task automatic test_gap();
    int cyc;
    send0(32'hFFFF_FFFF, 1'b0);
    b0.in_data = 32'h1234_5678;
    repeat (2) @(negedge clk);
    send0(32'hFFFF_FFFF, 1'b0);
    send0(32'hFFFF_FFFF, 1'b1);
    wait_out0(cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL gap_latency got %0d want 2", cyc); end
    n_cmp++; if (b0.out_sum !== 16'h0BF4) begin n_err++; $display("FAIL gap_sum got %h want 0bf4", b0.out_sum); end
    n_cmp++; if (b0.out_ovf !== 1'b0) begin n_err++; $display("FAIL gap_ovf got %0b want 0", b0.out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int cyc;
    for (int i = 0; i < 257; i++) begin
      send0(32'hFFFF_FFFF, (i == 256));
    end
    wait_out0(cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL ovf_latency got %0d want 2", cyc); end
    n_cmp++; if (b0.out_sum !== 16'hFFFC) begin n_err++; $display("FAIL ovf_sum got %h want fffc", b0.out_sum); end
    n_cmp++; if (b0.out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", b0.out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    b0.out_ready = 1'b0;
    send0({8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
    wait_out0(cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL bp_latency got %0d want 2", cyc); end
    b0.in_valid = 1'b1;
    b0.in_data  = 32'hFFFF_FFFF;
    b0.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b0.out_valid !== 1'b1 || b0.out_sum !== 16'h00A0 || b0.out_ovf !== 1'b0 || b0.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got valid=%0b sum=%h ovf=%0b ready=%0b want 1/00a0/0/0", i, b0.out_valid, b0.out_sum, b0.out_ovf, b0.in_ready);
      end
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", b0.out_valid, b0.in_ready); end
    b0.in_valid = 1'b0;
    b0.in_last  = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_not_absorbed in_ready got %0b want 1", b0.in_ready); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    send0({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0 || b0.out_sum !== 16'h0 || b0.out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL abort_outputs got ready=%0b valid=%0b sum=%h ovf=%0b want 1/0/0000/0", b0.in_ready, b0.out_valid, b0.out_sum, b0.out_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_result got %0b want 0", b0.out_valid); end
    send0({8'd0, 8'd0, 8'd0, 8'd5}, 1'b1);
    wait_out0(cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL abort_next_latency got %0d want 2", cyc); end
    n_cmp++; if (b0.out_sum !== 16'd5 || b0.out_ovf !== 1'b0) begin n_err++; $display("FAIL abort_next got sum=%0d ovf=%0b want 5/0", b0.out_sum, b0.out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_wide_ops();
    int cyc;
    b1.in_valid = 1'b1;
    b1.in_data  = 32'hFFFF_FFFF;
    b1.in_last  = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.in_last  = 1'b0;
    wait_out1(cyc);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL wide_latency got %0d want 3", cyc); end
    n_cmp++; if (b1.out_sum !== 8'h78) begin n_err++; $display("FAIL wide_sum got %h want 78", b1.out_sum); end
    n_cmp++; if (b1.out_ovf !== 1'b0) begin n_err++; $display("FAIL wide_ovf got %0b want 0", b1.out_ovf); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_beat();
    test_gap();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    test_wide_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
